// File: rtl/aidan_mcnay_mul_if.sv
// Operand/result val-rdy stream bundle for the iterative shift-add multiplier.
// The master drives the operands and accepts the result. The slave is the multiplier.
interface aidan_mcnay_mul_if #(
  parameter int nbits = 32
);
  logic [nbits-1:0] opa;
  logic [nbits-1:0] opb;
  logic             istream_val;
  logic             istream_rdy;
  logic [nbits-1:0] result;
  logic             ostream_val;
  logic             ostream_rdy;

  modport master (
    output opa, opb, istream_val, ostream_rdy,
    input  istream_rdy, result, ostream_val
  );

  modport slave (
    input  opa, opb, istream_val, ostream_rdy,
    output istream_rdy, result, ostream_val
  );
endinterface

// File: rtl/aidan_mcnay_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, low nbits kept.
// The latency is fixed at nbits CALC cycles. It does not stop early when the multiplier runs out of ones.
module aidan_mcnay_mul #(
  parameter int nbits = 32
) (
  input  logic              clk,
  input  logic              reset,
  aidan_mcnay_mul_if.slave  bus
);

  localparam int CW = (nbits > 2) ? $clog2(nbits) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] a_q, a_d;
  logic [nbits-1:0] b_q, b_d;
  logic [nbits-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.istream_val)     state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST)   state_d = DONE;
      DONE:    if (bus.ostream_rdy)     state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.istream_rdy = (state_q == IDLE);
    bus.ostream_val = (state_q == DONE);
    bus.result      = acc_q;
  end

  // Datapath next-state. The adder wraps, so the carry out of the top bit is lost.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.istream_val) begin
          a_d   = bus.opa;
          b_d   = bus.opb;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_mul.sv
// Bench for aidan_mcnay_mul at nbits=32 and nbits=8.
// Expected products come from plain wide multiplication truncated to nbits.
module tb_aidan_mcnay_mul;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aidan_mcnay_mul_if #(.nbits(32)) b32 ();
  aidan_mcnay_mul_if #(.nbits(8))  b8 ();

  aidan_mcnay_mul #(.nbits(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  aidan_mcnay_mul #(.nbits(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  function automatic logic [31:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return 8'(p % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 32-bit unit.
  // lat is the number of the edge, counted from the handshake edge, at which a consumer first sees ostream_val high.
  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!b32.istream_rdy && n < 100) begin tick(); n++; end
    b32.opa = a; b32.opb = b; b32.istream_val = 1'b1; b32.ostream_rdy = 1'b1;
    tick();
    b32.istream_val = 1'b0;
    b32.opa = $urandom; b32.opb = $urandom;
    n = 0;
    while (!b32.ostream_val && n < 200) begin tick(); n++; end
    res = b32.result;
    lat = n + 1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    tests++;
    if (b32.istream_rdy !== 1'b1) begin fails++; $display("FAIL reset_istream_rdy got %b want 1", b32.istream_rdy); end
    tests++;
    if (b32.ostream_val !== 1'b0) begin fails++; $display("FAIL reset_ostream_val got %b want 0", b32.ostream_val); end
    tests++;
    if (b32.result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", b32.result); end
    tests++;
    if (b8.istream_rdy !== 1'b1 || b8.ostream_val !== 1'b0) begin
      fails++; $display("FAIL reset_n8 rdy %b val %b want 1 0", b8.istream_rdy, b8.ostream_val);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat;
    run32(32'd3, 32'd5, r, lat);
    tests++;
    if (r !== 32'd15) begin fails++; $display("FAIL basic_result got %0d want 15", r); end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL basic_latency got %0d want 33", lat); end
  endtask

  task automatic test_wrap();
    logic [31:0] r; int lat;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    tests++;
    if (r !== 32'h0000_0001) begin fails++; $display("FAIL wrap_ffff got %h want 00000001", r); end
    run32(32'h8000_0000, 32'd2, r, lat);
    tests++;
    if (r !== 32'd0) begin fails++; $display("FAIL wrap_msb got %h want 00000000", r); end
  endtask

  task automatic test_zero_identity();
    logic [31:0] r; int lat;
    run32(32'd0, 32'hDEAD_BEEF, r, lat);
    tests++;
    if (r !== 32'd0) begin fails++; $display("FAIL zero_result got %h want 0", r); end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL zero_latency got %0d want 33", lat); end
    run32(32'd1, 32'hDEAD_BEEF, r, lat);
    tests++;
    if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL identity_result got %h want deadbeef", r); end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL identity_latency got %0d want 33", lat); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, r; int n, lat;
    exp = ref32(32'd123457, 32'd1001);
    b32.opa = 32'd123457; b32.opb = 32'd1001;
    b32.istream_val = 1'b1; b32.ostream_rdy = 1'b0;
    tick();
    b32.istream_val = 1'b0;
    n = 0;
    while (!b32.ostream_val && n < 200) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      b32.istream_val = 1'b1; b32.opa = $urandom; b32.opb = $urandom;
      tests++;
      if (b32.result !== exp || b32.ostream_val !== 1'b1 || b32.istream_rdy !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold cyc %0d result %h val %b rdy %b want %h 1 0",
                 i, b32.result, b32.ostream_val, b32.istream_rdy, exp);
      end
      tick();
    end
    b32.istream_val = 1'b0; b32.ostream_rdy = 1'b1;
    tick();
    tests++;
    if (b32.istream_rdy !== 1'b1 || b32.ostream_val !== 1'b0) begin
      fails++; $display("FAIL backpressure_release rdy %b val %b want 1 0", b32.istream_rdy, b32.ostream_val);
    end
    run32(32'd77, 32'd1000, r, lat);
    tests++;
    if (r !== 32'd77000) begin fails++; $display("FAIL backpressure_next got %0d want 77000", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat;
    b32.opa = 32'h0000_FFFF; b32.opb = 32'h0000_FFFF;
    b32.istream_val = 1'b1; b32.ostream_rdy = 1'b1;
    tick();
    b32.istream_val = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (b32.ostream_val !== 1'b0 || b32.istream_rdy !== 1'b1) begin
      fails++; $display("FAIL reset_mid_ctrl val %b rdy %b want 0 1", b32.ostream_val, b32.istream_rdy);
    end
    tests++;
    if (b32.result !== 32'd0) begin fails++; $display("FAIL reset_mid_acc got %h want 0", b32.result); end
    tick();
    reset = 1'b0;
    tick();
    run32(32'd7, 32'd6, r, lat);
    tests++;
    if (r !== 32'd42) begin fails++; $display("FAIL reset_mid_next got %0d want 42", r); end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL reset_mid_latency got %0d want 33", lat); end
  endtask

  // With operands always offered and the result always taken, accepts are nbits+2 cycles apart.
  task automatic test_initiation_interval();
    int fires, t0, t1, n;
    fires = 0; t0 = 0; t1 = 0; n = 0;
    b32.istream_val = 1'b1; b32.ostream_rdy = 1'b1;
    while (fires < 2 && n < 200) begin
      b32.opa = $urandom; b32.opb = $urandom;
      if (b32.istream_val && b32.istream_rdy) begin
        if (fires == 0) t0 = cyc; else t1 = cyc;
        fires++;
      end
      tick(); n++;
    end
    b32.istream_val = 1'b0;
    tests++;
    if (fires != 2 || (t1 - t0) != 34) begin
      fails++; $display("FAIL initiation_interval got %0d (fires %0d) want 34", t1 - t0, fires);
    end
    n = 0;
    while (!b32.ostream_val && n < 200) begin tick(); n++; end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp;
    int issued, done, guard;
    issued = 0; done = 0; guard = 0;
    while (done < 1000 && guard < 60000) begin
      b32.istream_val = (issued < 1000) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       b32.opa = 32'hFFFF_FFFF;
        1:       b32.opa = 32'd0;
        default: b32.opa = $urandom;
      endcase
      b32.opb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b32.ostream_rdy = ($urandom_range(0, 3) != 0);
      if (b32.istream_val && b32.istream_rdy) begin
        q.push_back(ref32(b32.opa, b32.opb));
        issued++;
      end
      if (b32.ostream_val && b32.ostream_rdy) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b32_spurious result %h with nothing outstanding", b32.result);
        end else begin
          exp = q.pop_front();
          if (b32.result !== exp) begin
            fails++; $display("FAIL b2b32_result #%0d got %h want %h", done, b32.result, exp);
          end
        end
        done++;
      end
      tick(); guard++;
    end
    b32.istream_val = 1'b0; b32.ostream_rdy = 1'b1;
    tests++;
    if (done < 1000) begin fails++; $display("FAIL b2b32_timeout got %0d results want 1000", done); end
    tick(); tick();
  endtask

  task automatic test_back_to_back_n8();
    logic [7:0] q[$];
    logic [7:0] exp;
    int issued, done, guard;
    issued = 0; done = 0; guard = 0;
    while (done < 1000 && guard < 25000) begin
      b8.istream_val = (issued < 1000) && ($urandom_range(0, 3) != 0);
      b8.opa = 8'($urandom);
      b8.opb = 8'($urandom);
      b8.ostream_rdy = ($urandom_range(0, 3) != 0);
      if (b8.istream_val && b8.istream_rdy) begin
        q.push_back(ref8(b8.opa, b8.opb));
        issued++;
      end
      if (b8.ostream_val && b8.ostream_rdy) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b8_spurious result %h with nothing outstanding", b8.result);
        end else begin
          exp = q.pop_front();
          if (b8.result !== exp) begin
            fails++; $display("FAIL b2b8_result #%0d got %h want %h", done, b8.result, exp);
          end
        end
        done++;
      end
      tick(); guard++;
    end
    b8.istream_val = 1'b0; b8.ostream_rdy = 1'b1;
    tests++;
    if (done < 1000) begin fails++; $display("FAIL b2b8_timeout got %0d results want 1000", done); end
  endtask

  initial begin
    b32.opa = '0; b32.opb = '0; b32.istream_val = 1'b0; b32.ostream_rdy = 1'b0;
    b8.opa  = '0; b8.opb  = '0; b8.istream_val  = 1'b0; b8.ostream_rdy  = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_identity();
    test_backpressure();
    test_reset_mid();
    test_initiation_interval();
    test_back_to_back();
    test_back_to_back_n8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
